muldiv_seq: RTL

//  Iterative RV32M multiply/divide sequencer beside the EX-stage ALU. It takes one
//  OP (0110011, funct7=0000001) op, runs a shift-add multiply or restoring divide over

---
 rtl/muldiv_seq.sv | 139 +++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiply, restoring divide, XLEN iterations.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply, divide unchanged.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            out_valid,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [2:0]      op;
  logic [XLEN-1:0] opnd, acc_hi, acc_lo;
  logic            neg_res, neg_rem;
  logic [CW-1:0]   cnt;

  logic            accept, sgn_a, sgn_b, div_zero, div_ovf, special, fast;
  logic [XLEN-1:0] abs_a, abs_b, special_res, fast_res, fix_res;
  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] prod, prod_s;

  assign accept = in_valid & in_ready & ~flush;

  // MUL counts as signed x signed; its low half is sign-agnostic anyway
  assign sgn_a = rs1[XLEN-1] & (funct3[2] ? ~funct3[0] : (funct3 != 3'b011));
  assign sgn_b = rs2[XLEN-1] & (funct3[2] ? ~funct3[0] : ~funct3[1]);
  assign abs_a = sgn_a ? -rs1 : rs1;
  assign abs_b = sgn_b ? -rs2 : rs2;

  assign div_zero = funct3[2] & (rs2 == '0);
  assign div_ovf  = funct3[2] & ~funct3[0] & (rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (rs2 == '1);
  assign special  = div_zero | div_ovf;
  always_comb begin
    special_res = '0;
    if (div_zero) special_res = funct3[1] ? rs1 : '1;
    else          special_res = funct3[1] ? '0 : rs1;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fprod, fprod_s;
  assign fast    = ~funct3[2];
  assign fprod   = {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
  assign fprod_s = (sgn_a ^ sgn_b) ? -fprod : fprod;
  assign fast_res = (funct3[1:0] == 2'b00) ? fprod_s[XLEN-1:0] : fprod_s[2*XLEN-1:XLEN];
`else
  assign fast     = 1'b0;
  assign fast_res = '0;
`endif

  // one iteration step of each algorithm
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd};
  end

  always_comb begin
    prod    = {acc_hi, acc_lo};
    prod_s  = neg_res ? -prod : prod;
    fix_res = '0;
    if (!op[2])     fix_res = (op[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    else if (op[1]) fix_res = neg_rem ? -acc_hi : acc_hi;
    else            fix_res = neg_res ? -acc_lo : acc_lo;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = (special | fast) ? S_DONE : (funct3[2] ? S_DIV : S_MUL);
      S_MUL, S_DIV: if (cnt == CW'(XLEN-1)) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    busy      = (state == S_MUL) | (state == S_DIV) | (state == S_FIX);
    out_valid = (state == S_DONE) & ~flush;
  end

  // acc_lo holds multiplier / dividend-then-quotient, acc_hi product high / partial remainder
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op <= '0; opnd <= '0; acc_hi <= '0; acc_lo <= '0;
      neg_res <= 1'b0; neg_rem <= 1'b0; cnt <= '0; result <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          op      <= funct3;
          neg_res <= sgn_a ^ sgn_b;
          neg_rem <= sgn_a;
          cnt     <= '0;
          if (special)   result <= special_res;
          else if (fast) result <= fast_res;
          else begin
            opnd   <= funct3[2] ? abs_b : abs_a;
            acc_hi <= '0;
            acc_lo <= funct3[2] ? abs_a : abs_b;
          end
        end
        S_MUL: begin
          acc_hi <= mul_sum[XLEN:1];
          acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
          cnt    <= cnt + 1'b1;
        end
        S_DIV: begin
          acc_hi <= div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
          acc_lo <= {acc_lo[XLEN-2:0], ~div_diff[XLEN]};
          cnt    <= cnt + 1'b1;
        end
        S_FIX: begin
          result <= fix_res;
          cnt    <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule
